decode_msg_buf: RTL

DECODE_MSG_BUF -- requirements
Module: decode_msg_buf

---
 rtl/decode_pkg.sv | 24 ++
 rtl/decode_msg_buf_if.sv | 21 ++
 rtl/decode_msg_bank.sv | 49 ++++
 rtl/decode_msg_buf.sv | 112 +++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode message buffer: security-level encodings,
// message sizing and the words-per-message helper.
package decode_pkg;

  typedef enum logic [1:0] {
    SEC_LIGHT   = 2'b00,
    SEC_SABER   = 2'b01,
    SEC_FIRE    = 2'b10,
    SEC_INVALID = 2'b11
  } sec_lvl_e;

  localparam int MSG_WORDS_MAX = 4;
  localparam int IDX_W         = 2;
  localparam int WPM_W         = 3;

  // Invalid level yields 0 so it can never match a word count.
  function automatic logic [WPM_W-1:0] words_per_msg(input logic [1:0] sec_lvl);
    if (sec_lvl == SEC_INVALID)
      words_per_msg = '0;
    else
      words_per_msg = {1'b0, sec_lvl} + 3'd2;
  endfunction

endpackage

// File: rtl/decode_msg_buf_if.sv
// Word stream in from the decode stage and out to the hash consumer.
interface decode_msg_buf_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] din;
  logic              din_val;
  logic [DATA_W-1:0] dout;
  logic              dout_val;
  logic              dout_last;
  logic              dout_ready;

  modport master (
    output din, din_val, dout_ready,
    input  dout, dout_val, dout_last
  );

  modport slave (
    input  din, din_val, dout_ready,
    output dout, dout_val, dout_last
  );
endinterface

// File: rtl/decode_msg_bank.sv
// One message bank: up to MSG_WORDS_MAX words, the word count captured with
// the first word, and a full flag owned jointly by the write and read sides.
module decode_msg_bank
  import decode_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [WPM_W-1:0]  wr_wpm,
  input  logic              set_full,
  input  logic              clr_full,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [WPM_W-1:0]  wpm,
  output logic              full
);

  logic [DATA_W-1:0] mem [MSG_WORDS_MAX];
  logic [WPM_W-1:0]  wpm_reg;
  logic              full_reg;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wpm_reg  <= '0;
      full_reg <= 1'b0;
    end else begin
      if (wr_en && wr_idx == '0)
        wpm_reg <= wr_wpm;
      if (set_full)
        full_reg <= 1'b1;
      else if (clr_full)
        full_reg <= 1'b0;
    end
  end

  assign rd_data = mem[rd_idx];
  assign wpm     = wpm_reg;
  assign full    = full_reg;

endmodule

// File: rtl/decode_msg_buf.sv
// Ping-pong message buffer between the decode stage and the hash consumer.
// Define DECODE_MSG_BUF_BSWAP_EN to byte-reverse dout for little-endian hash lanes.
module decode_msg_buf
  import decode_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NBANK  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sec_lvl,
  decode_msg_buf_if.slave  bus,
  output logic             overflow
);

  logic [NBANK-1:0]  bank_full;
  logic [DATA_W-1:0] bank_rd_data [NBANK];
  logic [WPM_W-1:0]  bank_wpm [NBANK];

  logic              wr_bank_reg;
  logic              rd_bank_reg;
  logic [IDX_W-1:0]  wr_cnt_reg;
  logic [IDX_W-1:0]  rd_cnt_reg;
  logic              overflow_reg;

  logic [WPM_W-1:0]  wr_wpm;
  logic              wr_accept;
  logic              wr_drop_full;
  logic              wr_last;
  logic              rd_xfer;
  logic              rd_last;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] out_word;

  // The first word of a message takes its length from sec_lvl; later words
  // use the length the bank latched, so mid-message level changes are ignored.
  always_comb begin
    wr_wpm       = (wr_cnt_reg == '0) ? words_per_msg(sec_lvl) : bank_wpm[wr_bank_reg];
    wr_drop_full = bus.din_val && bank_full[wr_bank_reg];
    wr_accept    = bus.din_val && !bank_full[wr_bank_reg] &&
                   !(wr_cnt_reg == '0 && sec_lvl == SEC_INVALID);
    wr_last      = wr_accept && ({1'b0, wr_cnt_reg} == wr_wpm - 3'd1);
    rd_xfer      = bank_full[rd_bank_reg] && bus.dout_ready;
    rd_last      = ({1'b0, rd_cnt_reg} == bank_wpm[rd_bank_reg] - 3'd1);
  end

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      localparam logic BANK_ID = 1'(gi);
      decode_msg_bank #(.DATA_W(DATA_W)) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_accept && wr_bank_reg == BANK_ID),
        .wr_idx   (wr_cnt_reg),
        .wr_data  (bus.din),
        .wr_wpm   (wr_wpm),
        .set_full (wr_last && wr_bank_reg == BANK_ID),
        .clr_full (rd_xfer && rd_last && rd_bank_reg == BANK_ID),
        .rd_idx   (rd_cnt_reg),
        .rd_data  (bank_rd_data[gi]),
        .wpm      (bank_wpm[gi]),
        .full     (bank_full[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      wr_cnt_reg   <= '0;
      rd_cnt_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_drop_full)
        overflow_reg <= 1'b1;
      if (wr_last) begin
        wr_bank_reg <= ~wr_bank_reg;
        wr_cnt_reg  <= '0;
      end else if (wr_accept) begin
        wr_cnt_reg  <= wr_cnt_reg + 1'b1;
      end
      if (rd_xfer) begin
        if (rd_last) begin
          rd_bank_reg <= ~rd_bank_reg;
          rd_cnt_reg  <= '0;
        end else begin
          rd_cnt_reg  <= rd_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rd_word = bank_rd_data[rd_bank_reg];

`ifdef DECODE_MSG_BUF_BSWAP_EN
  generate
    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_bswap
      assign out_word[8*gi +: 8] = rd_word[DATA_W-8-8*gi +: 8];
    end
  endgenerate
`else
  assign out_word = rd_word;
`endif

  // Gate with full so dout reads 0 while nothing is held (bank data is not reset).
  assign bus.dout      = bank_full[rd_bank_reg] ? out_word : '0;
  assign bus.dout_val  = bank_full[rd_bank_reg];
  assign bus.dout_last = bank_full[rd_bank_reg] && rd_last;
  assign overflow      = overflow_reg;

endmodule
